vga_plot_arbiter: RTL and testbench

//  Shares the single vga_adapter write port (x, y, colour, plot) between N pixel requesters:

---
 rtl/vga_plot_arbiter_pkg.sv | 29 ++
 rtl/vga_plot_arbiter_rr_arbiter.sv | 39 +++
 rtl/vga_plot_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared definitions for the VGA plot arbiter.
// - Screen geometry and coordinate/colour widths seen by vga_adapter.
// - Named colour constants (RGB, one bit per channel).
// - Clear engine state encoding.
package vga_plot_arbiter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    localparam logic [COL_W-1:0] BLACK  = 3'b000;
    localparam logic [COL_W-1:0] BLUE   = 3'b001;
    localparam logic [COL_W-1:0] GREEN  = 3'b010;
    localparam logic [COL_W-1:0] RED    = 3'b100;
    localparam logic [COL_W-1:0] YELLOW = 3'b110;
    localparam logic [COL_W-1:0] WHITE  = 3'b111;

    // Last column / row of the screen; the clear engine wraps on these.
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/vga_plot_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Scans req starting at rr_ptr (rr_ptr, rr_ptr+1, ... mod N_REQ) and grants
// the first asserted request.
// Ports:
//   req       in   N_REQ  request vector
//   rr_ptr    in   IDX_W  index with highest priority this cycle
//   gnt       out  N_REQ  one-hot grant (all zero when no request)
//   gnt_idx   out  IDX_W  index of the granted requester
//   gnt_valid out  1      some request was granted
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            // First hit wins; gnt_valid masks every later candidate.
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the single vga_adapter write port between N_REQ pixel requesters and
// a built-in full-screen clear engine that pre-empts all of them.
//
// Handshake: requester i holds req[i] and its data slice until gnt[i]=1; the
// pixel is transferred on that clock edge. Dropping req without a grant is
// legal and plots nothing. gnt is combinational and at most one-hot.
//
// Ports:
//   CLOCK_50      in   system clock, posedge
//   resetn        in   asynchronous active-low reset
//   req           in   request vector, one bit per requester
//   req_x/y/colour in  packed per-requester pixel data, slice i = [W*i +: W]
//   gnt           out  combinational one-hot grant (0 while clearing/reset)
//   clear_start   in   pulse: start a full-screen clear (ignored if busy)
//   clear_colour  in   fill colour, sampled with clear_start
//   clear_busy    out  clear engine active
//   clear_done    out  one-cycle pulse alongside the last clear pixel
//   x, y, colour  out  registered pixel to vga_adapter
//   plot          out  registered write strobe to vga_adapter
//   dbg_state     out  clear engine state (0 idle, 1 clearing)
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req,
    input  logic [X_W*N_REQ-1:0]   req_x,
    input  logic [Y_W*N_REQ-1:0]   req_y,
    input  logic [COL_W*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   clear_start,
    input  logic [COL_W-1:0]       clear_colour,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COL_W-1:0]       colour,
    output logic                   plot,
    output logic                   dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    clr_state_e       state_q,   state_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [X_W-1:0]   cx_q,      cx_d;
    logic [Y_W-1:0]   cy_q,      cy_d;
    logic [COL_W-1:0] clr_col_q, clr_col_d;
    logic [X_W-1:0]   x_q,       x_d;
    logic [Y_W-1:0]   y_q,       y_d;
    logic [COL_W-1:0] colour_q,  colour_d;
    logic             plot_q,    plot_d;
    logic             done_q,    done_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             grant_ok;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Requesters are only served when idle and no clear is being launched;
    // a clear_start in the same cycle wins and rr_ptr stays put.
    assign grant_ok = resetn && (state_q == ST_IDLE) && !clear_start;
    assign gnt      = grant_ok ? arb_gnt : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        clr_col_d = clr_col_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    cx_d      = '0;
                    cy_d      = '0;
                    clr_col_d = clear_colour;
                end else if (grant_ok && arb_valid) begin
                    x_d      = req_x[X_W*int'(arb_idx) +: X_W];
                    y_d      = req_y[Y_W*int'(arb_idx) +: Y_W];
                    colour_d = req_colour[COL_W*int'(arb_idx) +: COL_W];
                    plot_d   = 1'b1;
                    rr_ptr_d = IDX_W'((int'(arb_idx) + 1) % N_REQ);
                end
            end
            ST_CLEAR: begin
                // clear_start is deliberately not looked at here, so a
                // re-trigger cannot restart the counters or the colour.
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = clr_col_q;
                plot_d   = 1'b1;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        // Last pixel goes out on this edge together with done.
                        cy_d    = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            clr_col_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            clr_col_q <= clr_col_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
        end
    end

    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single grant, round robin,
// full clear, clear re-trigger and reset in the middle of a clear.
module tb_vga_plot_arbiter;
    import vga_plot_arbiter_pkg::*;

    localparam int N = 4;
    localparam int TOTAL_PIX = SCREEN_W * SCREEN_H;

    logic                 clk;
    logic                 resetn;
    logic [N-1:0]         req;
    logic [X_W*N-1:0]     req_x;
    logic [Y_W*N-1:0]     req_y;
    logic [COL_W*N-1:0]   req_colour;
    logic [N-1:0]         gnt;
    logic                 clear_start;
    logic [COL_W-1:0]     clear_colour;
    logic                 clear_busy;
    logic                 clear_done;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [COL_W-1:0]     colour;
    logic                 plot;
    logic                 dbg_state;

    int errors = 0;
    int checks = 0;

    // Aggregated results of one clear_loop call.
    int bad_gnt;
    int bad_pix;
    int bad_done;
    int done_cnt;

    vga_plot_arbiter #(.N_REQ(N)) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .gnt          (gnt),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_pixel(input int i, input logic [X_W-1:0] px,
                             input logic [Y_W-1:0] py, input logic [COL_W-1:0] pc);
        req_x[X_W*i +: X_W]           = px;
        req_y[Y_W*i +: Y_W]           = py;
        req_colour[COL_W*i +: COL_W]  = pc;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n_pix busy cycles of a clear that started at pixel 0 and compares
    // every emitted pixel with the row-major reference. At pixel retrig_p a
    // one-cycle clear_start with WHITE is injected (negative: never).
    task automatic clear_loop(input int n_pix, input logic [COL_W-1:0] col, input int retrig_p);
        int ex;
        int ey;
        bad_gnt  = 0;
        bad_pix  = 0;
        bad_done = 0;
        done_cnt = 0;
        for (int p = 0; p < n_pix; p++) begin
            if (p == retrig_p) begin
                clear_start  = 1'b1;
                clear_colour = WHITE;
                settle();
            end
            if (gnt !== '0) bad_gnt++;
            tick();
            clear_start = 1'b0;
            ex = p % SCREEN_W;
            ey = p / SCREEN_W;
            if (x !== X_W'(ex) || y !== Y_W'(ey) || colour !== col || plot !== 1'b1)
                bad_pix++;
            if (clear_done === 1'b1) done_cnt++;
            if (clear_done !== (p == TOTAL_PIX - 1)) bad_done++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetn       = 1'b0;
        req          = 4'b1111;
        req_x        = '0;
        req_y        = '0;
        req_colour   = '0;
        clear_start  = 1'b0;
        clear_colour = BLACK;

        // 1: reset held with all requests up
        repeat (3) tick();
        check("rst_gnt",    32'(gnt), 32'h0);
        check("rst_plot",   32'(plot), 32'h0);
        check("rst_x",      32'(x), 32'h0);
        check("rst_y",      32'(y), 32'h0);
        check("rst_colour", 32'(colour), 32'h0);
        check("rst_busy",   32'(clear_busy), 32'h0);
        check("rst_done",   32'(clear_done), 32'h0);
        req    = '0;
        resetn = 1'b1;
        tick();

        // 2: single requester 2
        set_pixel(2, 8'd37, 7'd5, RED);
        req = 4'b0100;
        settle();
        check("single_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        check("single_x",      32'(x), 32'd37);
        check("single_y",      32'(y), 32'd5);
        check("single_colour", 32'(colour), 32'd4);
        check("single_plot",   32'(plot), 32'h1);
        settle();
        check("idle_gnt", 32'(gnt), 32'h0);
        tick();
        check("idle_plot",   32'(plot), 32'h0);
        check("idle_x_hold", 32'(x), 32'd37);

        // Brief asynchronous reset so the pointer starts at 0 again.
        resetn = 1'b0;
        settle();
        check("pulse_rst_x", 32'(x), 32'h0);
        resetn = 1'b1;
        tick();

        // 3: round robin with all four requesting
        for (int i = 0; i < N; i++)
            set_pixel(i, X_W'(10 + i), Y_W'(20 + i), COL_W'(i + 1));
        req = 4'b1111;
        settle();
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
            tick();
            check("rr_plot", 32'(plot), 32'h1);
            check("rr_x",    32'(x), 32'(10 + (k % N)));
            check("rr_col",  32'(colour), 32'((k % N) + 1));
        end
        req = '0;
        tick();
        check("rr_plot_off", 32'(plot), 32'h0);

        // 4: full clear with concurrent req[0]; rr_ptr is 1 at this point
        clear_start  = 1'b1;
        clear_colour = BLACK;
        req          = 4'b0001;
        settle();
        check("clr_start_gnt", 32'(gnt), 32'h0);
        tick();
        clear_start = 1'b0;
        check("clr_busy",       32'(clear_busy), 32'h1);
        check("clr_first_plot", 32'(plot), 32'h0);
        clear_loop(TOTAL_PIX, BLACK, -1);
        check("clr_gnt_held", 32'(bad_gnt), 32'h0);
        check("clr_pixels",   32'(bad_pix), 32'h0);
        check("clr_done_pos", 32'(bad_done), 32'h0);
        check("clr_done_cnt", 32'(done_cnt), 32'h1);
        check("clr_busy_end", 32'(clear_busy), 32'h0);
        check("clr_gnt_after", 32'(gnt), 32'h1);
        tick();
        req = '0;
        check("post_clr_x",    32'(x), 32'd10);
        check("post_clr_plot", 32'(plot), 32'h1);
        check("post_clr_done", 32'(clear_done), 32'h0);

        // 5: re-trigger at pixel 500 is ignored
        clear_start  = 1'b1;
        clear_colour = BLUE;
        tick();
        clear_start = 1'b0;
        clear_loop(TOTAL_PIX, BLUE, 500);
        check("retrig_pixels",   32'(bad_pix), 32'h0);
        check("retrig_done_pos", 32'(bad_done), 32'h0);
        check("retrig_done_cnt", 32'(done_cnt), 32'h1);
        tick();
        check("retrig_busy_end", 32'(clear_busy), 32'h0);
        check("retrig_done_off", 32'(clear_done), 32'h0);

        // 6: reset in the middle of a clear
        clear_start  = 1'b1;
        clear_colour = GREEN;
        tick();
        clear_start = 1'b0;
        req         = 4'b1000;
        clear_loop(1000, GREEN, -1);
        check("mid_pixels", 32'(bad_pix), 32'h0);
        check("mid_gnt",    32'(bad_gnt), 32'h0);
        resetn = 1'b0;
        settle();
        check("mid_rst_plot",   32'(plot), 32'h0);
        check("mid_rst_x",      32'(x), 32'h0);
        check("mid_rst_y",      32'(y), 32'h0);
        check("mid_rst_colour", 32'(colour), 32'h0);
        check("mid_rst_busy",   32'(clear_busy), 32'h0);
        check("mid_rst_gnt",    32'(gnt), 32'h0);
        resetn = 1'b1;
        settle();
        check("rel_busy", 32'(clear_busy), 32'h0);
        check("rel_gnt",  32'(gnt), 32'h8);
        tick();
        req = '0;
        check("rel_x",    32'(x), 32'd13);
        check("rel_y",    32'(y), 32'd23);
        check("rel_plot", 32'(plot), 32'h1);
        tick();
        check("rel_plot_off", 32'(plot), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
